// File: rtl/enc_prio_hs.sv
// enc_prio_hs: sticky-pending fixed-priority encoder offering one index at a time over a V/ack handshake
module enc_prio_hs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         E,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] Y,
  output logic         V,
  output logic [N-1:0] pend,
  output logic         dup
);
  if (W != $clog2(N)) begin : g_bad_w
    $error("enc_prio_hs: W must equal $clog2(N)");
  end
  typedef enum logic {IDLE, OFERTA} state_t;
  state_t state, state_n;
  logic [N-1:0] cap, clr;
  logic [W-1:0] sel;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (|pend ? OFERTA : IDLE) : (ack ? IDLE : OFERTA);
  always_comb begin
    V = state == OFERTA;
    cap = E ? req : '0;
    clr = V && ack ? N'(1) << Y : '0;
  end
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--)
      if (pend[i]) sel = W'(i);
  end
  always_ff @(posedge clk)
    if (rst) begin
      pend <= '0;
      Y <= '0;
      dup <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | cap;
      dup <= |(cap & pend & ~clr);
      if (state == IDLE && |pend) Y <= sel;
    end
endmodule
